// File: rtl/rr_encoder_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the round-robin arbiter (slave).
interface rr_encoder_arbiter_8_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_encoder_arbiter_8.sv
// Round-robin arbiter for 8 requesters; registered one-hot grant plus 3-bit index. Optional macro: GRANT_TIMEOUT_EN.
// Latency: one cycle from req to gnt; an owner release hands over on the same edge with no idle gap.
// Backpressure: grant held while the owner keeps req; with GRANT_TIMEOUT_EN rotation is forced after MAX_HOLD cycles.
module rr_encoder_arbiter_8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_encoder_arbiter_8_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W:0]   win;
    logic [IDX_W:0]   rot;
    logic             to_d;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 1..255");
    end

    // Returns {found, index} of the first set bit searching upward from last+1 with wrap.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] c;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            c = last + IDX_W'(k);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign win = pick(bus.req, last_q);
    assign rot = pick(bus.req & ~gnt_q, idx_q);

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       to_q;
`endif

    always_comb begin
        state_nxt = state;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        to_d      = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state)
            IDLE: begin
                if (win[IDX_W]) begin
                    state_nxt = GRANT;
                    gnt_d     = N'(1) << win[IDX_W-1:0];
                    idx_d     = win[IDX_W-1:0];
                    last_d    = win[IDX_W-1:0];
`ifdef GRANT_TIMEOUT_EN
                    hold_d    = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[idx_q]) begin
                    if (win[IDX_W]) begin
                        gnt_d  = N'(1) << win[IDX_W-1:0];
                        idx_d  = win[IDX_W-1:0];
                        last_d = win[IDX_W-1:0];
`ifdef GRANT_TIMEOUT_EN
                        hold_d = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                        gnt_d     = '0;
                    end
                end
`ifdef GRANT_TIMEOUT_EN
                // Owner still requesting: rotate only if someone else is waiting, else saturate.
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    if (rot[IDX_W]) begin
                        gnt_d  = N'(1) << rot[IDX_W-1:0];
                        idx_d  = rot[IDX_W-1:0];
                        last_d = rot[IDX_W-1:0];
                        hold_d = '0;
                        to_d   = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            idx_q  <= '0;
            last_q <= IDX_W'(N - 1);
`ifdef GRANT_TIMEOUT_EN
            hold_q <= '0;
            to_q   <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_d;
            idx_q  <= idx_d;
            last_q <= last_d;
`ifdef GRANT_TIMEOUT_EN
            hold_q <= hold_d;
            to_q   <= to_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
`ifdef GRANT_TIMEOUT_EN
    assign bus.timeout   = to_q;
`else
    assign bus.timeout   = 1'b0;
    logic unused_to;
    assign unused_to     = to_d | rot[IDX_W];
`endif
endmodule
